// File: rtl/riscv_dbg_pkg.sv
// Shared debug definitions: beat kind encodings, dump FSM states and the
// default datapath width also used by data_path.
package riscv_dbg_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    KIND_REG = 2'd0,
    KIND_MEM = 2'd1,
    KIND_CYC = 2'd2
  } beat_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REGS = 2'd1,
    ST_MEM  = 2'd2,
    ST_CYC  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/halt_detector.sv
// Declares halt when the PC stays put for HALT_CYCLES cycles and counts the
// cycles the core ran before that.
module halt_detector
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int HALT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            halted_o,
  output logic [XLEN-1:0] cycle_count_o
);

  localparam int SW = $clog2(HALT_CYCLES);
  localparam logic [SW-1:0] SAME_MAX = SW'(HALT_CYCLES - 1);

  logic [XLEN-1:0] pc_prev_q;
  logic [XLEN-1:0] count_q, count_d;
  logic [SW-1:0]   same_q, same_d;
  logic            halted_q, halted_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    same_d   = '0;
    halted_d = 1'b0;
    count_d  = count_q;
    if (run_i) begin
      if (pc_i == pc_prev_q) begin
        same_d = (same_q == SAME_MAX) ? same_q : same_q + SW'(1);
      end
      halted_d = halted_q || (same_d == SAME_MAX);
      // Counting stops once halted and pins at all-ones instead of wrapping.
      if (!halted_q && (count_q != '1)) begin
        count_d = count_q + XLEN'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_prev_q <= '0;
      same_q    <= '0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      pc_prev_q <= pc_i;
      same_q    <= same_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign halted_o      = halted_q;
  assign cycle_count_o = count_q;

endmodule

// File: rtl/debug_dump_unit.sv
// Streams the register file, a RAM window and the run-cycle count over a
// valid/ready link when the core halts or a dump is requested.
module debug_dump_unit
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int NUM_REGS    = 32,
  parameter int RF_AW       = 5,
  parameter int DM_AW       = 8,
  parameter int HALT_CYCLES = 4,
  parameter int AUTO_DUMP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             dump_req_i,
  input  logic [DM_AW-1:0] mem_base_i,
  input  logic [DM_AW-1:0] mem_len_i,
  output logic [RF_AW-1:0] rf_raddr_o,
  input  logic [XLEN-1:0]  rf_rdata_i,
  output logic [DM_AW-1:0] dm_raddr_o,
  input  logic [XLEN-1:0]  dm_rdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_kind_o,
  output logic [DM_AW-1:0] out_addr_o,
  output logic [XLEN-1:0]  out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [XLEN-1:0]  cycle_count_o
);

  localparam int IDX_W = (RF_AW > DM_AW) ? RF_AW : DM_AW;
  localparam logic [DM_AW-1:0] DM_ONE = DM_AW'(1);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DM_AW-1:0] base_q, base_d;
  logic [DM_AW-1:0] len_q, len_d;
  logic             halted_prev_q;

  logic             valid_q, valid_d;
  beat_kind_e       kind_q, kind_d;
  logic [DM_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             last_q, last_d;

  logic             load;
  logic             trigger;
  logic [DM_AW-1:0] mem_addr;

  halt_detector #(
    .XLEN        (XLEN),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run_i),
    .pc_i          (pc_i),
    .halted_o      (halted_o),
    .cycle_count_o (cycle_count_o)
  );

  // A request and a halt edge in the same cycle collapse into one trigger.
  assign trigger  = dump_req_i || ((AUTO_DUMP != 0) && halted_o && !halted_prev_q);
  assign load     = !valid_q || out_ready_i;
  assign mem_addr = base_q + idx_q[DM_AW-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    len_d   = len_q;
    valid_d = valid_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_REGS;
          idx_d   = '0;
          base_d  = mem_base_i;
          len_d   = mem_len_i;
        end
      end

      ST_REGS: begin
        if (load) begin
          valid_d = 1'b1;
          kind_d  = KIND_REG;
          addr_d  = DM_AW'(idx_q);
          data_d  = rf_rdata_i;
          last_d  = 1'b0;
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            idx_d   = '0;
            state_d = (len_q != '0) ? ST_MEM : ST_CYC;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_MEM: begin
        if (load) begin
          valid_d = 1'b1;
          kind_d  = KIND_MEM;
          addr_d  = mem_addr;
          data_d  = dm_rdata_i;
          last_d  = 1'b0;
          if (idx_q[DM_AW-1:0] == (len_q - DM_ONE)) begin
            idx_d   = '0;
            state_d = ST_CYC;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_CYC: begin
        // out_last marks that the count beat is already sitting in the
        // output register; from then on only its acceptance matters.
        if (last_q) begin
          if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (load) begin
          valid_d = 1'b1;
          kind_d  = KIND_CYC;
          addr_d  = '0;
          data_d  = cycle_count_o;
          last_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      base_q        <= '0;
      len_q         <= '0;
      halted_prev_q <= 1'b0;
      valid_q       <= 1'b0;
      kind_q        <= KIND_REG;
      addr_q        <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      len_q         <= len_d;
      halted_prev_q <= halted_o;
      valid_q       <= valid_d;
      kind_q        <= kind_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      last_q        <= last_d;
    end
  end

  assign rf_raddr_o  = idx_q[RF_AW-1:0];
  assign dm_raddr_o  = mem_addr;
  assign out_valid_o = valid_q;
  assign out_kind_o  = kind_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_dump_unit.sv
// Self-checking bench for debug_dump_unit: random memory contents and link
// backpressure, checked against a beat list built from the dump rules.
module tb_debug_dump_unit;

  localparam int XLEN        = 32;
  localparam int NUM_REGS    = 32;
  localparam int RF_AW       = 5;
  localparam int DM_AW       = 8;
  localparam int HALT_CYCLES = 4;
  localparam int BUDGET      = 3000;

  localparam logic [1:0] K_REG = 2'd0;
  localparam logic [1:0] K_MEM = 2'd1;
  localparam logic [1:0] K_CYC = 2'd2;

  typedef logic [2+DM_AW+XLEN:0] beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run_i = 1'b0;
  logic [XLEN-1:0]  pc_i = '0;
  logic             dump_req_i = 1'b0;
  logic [DM_AW-1:0] mem_base_i = '0;
  logic [DM_AW-1:0] mem_len_i = '0;
  logic             out_ready_i = 1'b1;
  logic [RF_AW-1:0] rf_raddr_o;
  logic [XLEN-1:0]  rf_rdata_i;
  logic [DM_AW-1:0] dm_raddr_o;
  logic [XLEN-1:0]  dm_rdata_i;
  logic             out_valid_o;
  logic [1:0]       out_kind_o;
  logic [DM_AW-1:0] out_addr_o;
  logic [XLEN-1:0]  out_data_o;
  logic             out_last_o;
  logic             busy_o;
  logic             halted_o;
  logic [XLEN-1:0]  cycle_count_o;

  logic [XLEN-1:0]  rf_mem [NUM_REGS];
  logic [XLEN-1:0]  ram    [1 << DM_AW];

  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t cur_beat;
  beat_t held;
  logic  stalled;

  int n_checks = 0;
  int n_errors = 0;

  debug_dump_unit #(
    .XLEN        (XLEN),
    .NUM_REGS    (NUM_REGS),
    .RF_AW       (RF_AW),
    .DM_AW       (DM_AW),
    .HALT_CYCLES (HALT_CYCLES),
    .AUTO_DUMP   (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run_i),
    .pc_i          (pc_i),
    .dump_req_i    (dump_req_i),
    .mem_base_i    (mem_base_i),
    .mem_len_i     (mem_len_i),
    .rf_raddr_o    (rf_raddr_o),
    .rf_rdata_i    (rf_rdata_i),
    .dm_raddr_o    (dm_raddr_o),
    .dm_rdata_i    (dm_rdata_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_kind_o    (out_kind_o),
    .out_addr_o    (out_addr_o),
    .out_data_o    (out_data_o),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .halted_o      (halted_o),
    .cycle_count_o (cycle_count_o)
  );

  always #5 clk = ~clk;

  assign rf_rdata_i = rf_mem[rf_raddr_o];
  assign dm_rdata_i = ram[dm_raddr_o];
  assign cur_beat   = {out_kind_o, out_addr_o, out_data_o, out_last_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Link monitor: records every transfer and insists a stalled beat is held.
  always @(negedge clk) begin
    if (!rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) check("hold", {out_valid_o, cur_beat}, {1'b1, held});
      if (out_valid_o && out_ready_i) got_q.push_back(cur_beat);
      stalled <= out_valid_o && !out_ready_i;
      held    <= cur_beat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mems();
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom();
    for (int i = 0; i < (1 << DM_AW); i++) ram[i] = $urandom();
  endtask

  // Expected dump: every register, then len RAM words from base (wrapping),
  // then the cycle count flagged as last.
  task automatic build_exp(input logic [DM_AW-1:0] base, input int len, input logic [XLEN-1:0] cyc);
    logic [DM_AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back({K_REG, DM_AW'(i), rf_mem[i], 1'b0});
    for (int i = 0; i < len; i++) begin
      a = DM_AW'((int'(base) + i) % (1 << DM_AW));
      exp_q.push_back({K_MEM, a, ram[a], 1'b0});
    end
    exp_q.push_back({K_CYC, {DM_AW{1'b0}}, cyc, 1'b1});
  endtask

  task automatic compare_dump(input string tag);
    int n;
    check($sformatf("%s_beats", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic wait_done(input string tag, input bit rnd, input bit pulse);
    int n = 0;
    while (n < BUDGET && !(got_q.size() > 0 && !busy_o)) begin
      if (rnd) out_ready_i = 1'($urandom_range(0, 1));
      dump_req_i = pulse && (n % 7 == 3);
      tick();
      n++;
    end
    dump_req_i  = 1'b0;
    out_ready_i = 1'b1;
    check($sformatf("%s_done", tag), (n < BUDGET), 1);
    check($sformatf("%s_quiet", tag), {busy_o, out_valid_o, out_last_o}, 3'b000);
  endtask

  task automatic run_dump(input string tag, input logic [DM_AW-1:0] base, input int len,
                          input logic [XLEN-1:0] cyc, input bit rnd, input bit pulse);
    fill_mems();
    mem_base_i = base;
    mem_len_i  = DM_AW'(len);
    got_q.delete();
    build_exp(base, len, cyc);
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    // Window inputs only matter at the start; scramble them afterwards.
    mem_base_i = DM_AW'($urandom());
    mem_len_i  = DM_AW'($urandom());
    wait_done(tag, rnd, pulse);
    compare_dump(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {out_valid_o, busy_o, halted_o, out_last_o}, 4'b0000);
    check({tag, "_count"}, cycle_count_o, 0);
    check({tag, "_data"}, out_data_o, 0);
    check({tag, "_kind_addr"}, {out_kind_o, out_addr_o}, 0);
    check({tag, "_raddr"}, {rf_raddr_o, dm_raddr_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [XLEN-1:0] cyc_first;
    logic [DM_AW-1:0] base;
    int n;

    fill_mems();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // PC walks up to 0x40 over 20 cycles, then sticks there.
    mem_base_i = 8'd12;
    mem_len_i  = 8'd1;
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      run_i = 1'b1;
      pc_i  = 32'h40 - 32'(4 * (19 - i));
      tick();
    end
    for (int k = 0; k < HALT_CYCLES - 1; k++) begin
      check($sformatf("not_halted%0d", k), halted_o, 0);
      tick();
    end
    cyc_first = 32'(20 + HALT_CYCLES - 1);
    check("halted", halted_o, 1);
    check("count_at_halt", cycle_count_o, cyc_first);
    build_exp(8'd12, 1, cyc_first);
    wait_done("auto", 1'b0, 1'b0);
    compare_dump("auto");
    check("count_frozen", cycle_count_o, cyc_first);

    // Latency: busy one cycle after the request, REG 0 one cycle later.
    fill_mems();
    mem_base_i = 8'd40;
    mem_len_i  = 8'd2;
    got_q.delete();
    build_exp(8'd40, 2, cyc_first);
    check("idle_before_req", busy_o, 0);
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    check("busy_after_req", {busy_o, out_valid_o}, 2'b10);
    tick();
    check("first_valid", out_valid_o, 1);
    check("first_beat", cur_beat, exp_q[0]);
    wait_done("latency", 1'b0, 1'b0);
    compare_dump("latency");

    base = DM_AW'($urandom());
    run_dump("backpressure", base, int'($urandom_range(1, 6)), cyc_first, 1'b1, 1'b0);
    run_dump("wrap", 8'hFE, 3, cyc_first, 1'b0, 1'b0);
    run_dump("len0", 8'h33, 0, cyc_first, 1'b1, 1'b0);

    // Extra requests while busy must be dropped, not queued.
    run_dump("collide", 8'd12, 1, cyc_first, 1'b0, 1'b1);
    repeat (5) tick();
    check("collide_no_requeue", {busy_o, 32'(got_q.size())}, {1'b0, 32'(exp_q.size())});

    // Drop run to clear the halt, then request in the very cycle halt re-rises.
    run_i = 1'b0;
    repeat (2) tick();
    check("halt_cleared", halted_o, 0);
    check("count_kept", cycle_count_o, cyc_first);
    fill_mems();
    mem_base_i = 8'd7;
    mem_len_i  = 8'd2;
    got_q.delete();
    build_exp(8'd7, 2, cyc_first + 32'(HALT_CYCLES - 1));
    run_i = 1'b1;
    n = 0;
    while (!halted_o && n < 20) begin
      tick();
      n++;
    end
    check("rehalt_cycles", n, HALT_CYCLES - 1);
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    wait_done("simul", 1'b0, 1'b0);
    compare_dump("simul");
    repeat (5) tick();
    check("simul_single", {busy_o, 32'(got_q.size())}, {1'b0, 32'(exp_q.size())});

    // Reset in the middle of a dump aborts it at once.
    run_i = 1'b0;
    fill_mems();
    mem_base_i = 8'd100;
    mem_len_i  = 8'd4;
    got_q.delete();
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    n = 0;
    while (got_q.size() < 10 && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach10", (n < 200), 1);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_dump("restart", 8'd100, 4, 32'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
